// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: drives one external full-adder cell LSB first,
// carrying through carry_q, and presents {cout, sum} over a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for an operand pair (in_ready high)
//   RUN   | one operand bit per clock through the full-adder cell
//   DONE  | result held on sum/cout until consumer takes it
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             last_bit;

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // fa_* come from registers only, so there is no loop through the external cell.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sum       = '0;
        cout      = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN: begin
                fa_a   = a_sh[0];
                fa_b   = b_sh[0];
                fa_cin = carry_q;
            end
            DONE: begin
                out_valid = 1'b1;
                sum       = sum_sh;
                cout      = carry_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_q <= op_cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=4 instance, each with its own
// behavioural full-adder cell, checked against plain-arithmetic expectations.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, op_cin, out_valid, out_ready, cout;
    logic [7:0] op_a, op_b, sum;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    logic       in_valid4, in_ready4, op_cin4, out_valid4, out_ready4, cout4;
    logic [3:0] op_a4, op_b4, sum4;
    logic       fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4;

    int n_cmp  = 0;
    int n_fail = 0;

    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
    assign fa_cout4 = (fa_a4 & fa_b4) | (fa_a4 & fa_cin4) | (fa_b4 & fa_cin4);

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .op_a(op_a4), .op_b(op_b4), .op_cin(op_cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4),
        .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4),
        .fa_sum(fa_sum4), .fa_cout(fa_cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a falling edge with dut8 in IDLE; returns at a falling edge in IDLE.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [7:0] es, input logic eco, input string tag);
        logic [7:0] ga, gb, gc, ec;
        logic       c;
        logic       early;
        c = cin;
        for (int k = 0; k < 8; k++) begin
            ec[k] = c;
            c = ((32'(a[k]) + 32'(b[k]) + 32'(c)) >= 2);
        end
        early = 1'b0;
        check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        op_cin    = cin;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ga[k] = fa_a;
            gb[k] = fa_b;
            gc[k] = fa_cin;
            if (out_valid) early = 1'b1;
            @(negedge clk);
        end
        check({tag, ":fa_a_seq"}, 32'(ga), 32'(a));
        check({tag, ":fa_b_seq"}, 32'(gb), 32'(b));
        check({tag, ":fa_cin_seq"}, 32'(gc), 32'(ec));
        check({tag, ":early_valid"}, 32'(early), 32'd0);
        check({tag, ":result"}, {22'd0, out_valid, cout, sum}, {22'd0, 1'b1, eco, es});
        check({tag, ":fa_idle"}, {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        @(negedge clk);
        check({tag, ":after_hs"}, {30'd0, in_ready, out_valid}, {30'd0, 2'b10});
    endtask

    vec_t vecs[9];
    int   acc_t[2];
    logic [3:0] rs4[2];
    logic       rc4[2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rcin;
        logic [8:0] exp9;
        int         lat, st, n_acc, n_res, gap;
        logic       seen;

        vecs[0] = '{8'hF0, 8'hCC, 1'b0, 8'hBC, 1'b1};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h01, 8'hFF, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; op_a4 = '0; op_b4 = '0; op_cin4 = 1'b0; out_ready4 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset8", {19'd0, in_ready, out_valid, cout, sum, fa_a, fa_b, fa_cin},
              {19'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000});
        check("reset4", {25'd0, in_ready4, out_valid4, cout4, sum4}, {25'd0, 7'b1000000});
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: result held, in_valid ignored, in_ready only after handshake.
        in_valid = 1'b1; op_a = 8'hAA; op_b = 8'h55; op_cin = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        for (int h = 0; h < 5; h++) begin
            check($sformatf("bp_hold%0d", h), {21'd0, in_ready, out_valid, cout, sum},
                  {21'd0, 1'b0, 1'b1, 1'b0, 8'hFF});
            if (h == 1) begin
                in_valid = 1'b1; op_a = 8'h01; op_b = 8'h01; op_cin = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_no_comb_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp_release", {30'd0, in_ready, out_valid}, {30'd0, 2'b10});
        run_op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "post_bp");

        // Reset during RUN cycle 3 abandons the operation.
        in_valid = 1'b1; op_a = 8'h12; op_b = 8'h34; op_cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_in_run", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {19'd0, in_ready, out_valid, cout, sum, fa_a, fa_b, fa_cin},
              {19'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'b000});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid || !in_ready) seen = 1'b1;
            @(negedge clk);
        end
        check("rst_no_valid", 32'(seen), 32'd0);
        run_op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_rst");

        // WIDTH=4 back-to-back with in_valid held high.
        in_valid4 = 1'b1; op_a4 = 4'h9; op_b4 = 4'h8; op_cin4 = 1'b0; out_ready4 = 1'b1;
        n_acc = 0; n_res = 0;
        for (int i = 0; i < 40 && n_res < 2; i++) begin
            if (in_valid4 && in_ready4 && n_acc < 2) begin
                acc_t[n_acc] = i;
                n_acc++;
            end
            if (out_valid4 && out_ready4 && n_res < 2) begin
                rs4[n_res] = sum4;
                rc4[n_res] = cout4;
                n_res++;
            end
            @(negedge clk);
            if (n_acc >= 1) begin
                op_a4 = 4'h7; op_b4 = 4'h7; op_cin4 = 1'b1;
            end
            if (n_acc >= 2) in_valid4 = 1'b0;
        end
        in_valid4 = 1'b0;
        check("w4_counts", {16'd0, 8'(n_acc), 8'(n_res)}, {16'd0, 8'd2, 8'd2});
        if (n_acc == 2) check("w4_accept_gap", 32'(acc_t[1] - acc_t[0]), 32'd6);
        if (n_res == 2) begin
            check("w4_res0", {27'd0, rc4[0], rs4[0]}, {27'd0, 1'b1, 4'h1});
            check("w4_res1", {27'd0, rc4[1], rs4[1]}, {27'd0, 1'b0, 4'hF});
        end

        // Random operands with random consumer stalls.
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rcin = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rcin};
            gap  = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            in_valid = 1'b1; op_a = ra; op_b = rb; op_cin = rcin;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("rand%0d_first", n), {15'd0, 8'(lat), cout, sum},
                  {15'd0, 8'd8, exp9});
            out_ready = 1'($urandom_range(0, 1));
            st = 0;
            while (!out_ready && st < 30) begin
                @(negedge clk);
                st++;
                out_ready = ($urandom_range(0, 2) == 0) || (st >= 20);
            end
            check($sformatf("rand%0d_hold", n), {22'd0, out_valid, cout, sum},
                  {22'd0, 1'b1, exp9});
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add sequencer that time-shares one external 1-bit full-adder cell (a, b, cin -> sum, cout) to add two WIDTH-bit operands. It accepts an operand pair over a valid/ready handshake and feeds the cell one bit per clock, LSB first. It feeds the carry back through an internal register and assembles the result in a shift register. It then presents the WIDTH-bit sum and final carry-out over a second valid/ready handshake. The full-adder instance sits beside this block at the same level, and this block is the only driver of its inputs.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- op_a  input  WIDTH  addend A, sampled on accept
- op_b  input  WIDTH  addend B, sampled on accept
- op_cin  input  1  initial carry-in, sampled on accept
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result bits, LSB = bit 0
- cout  output  1  carry out of bit WIDTH-1
- fa_a  output  1  to full-adder a
- fa_b  output  1  to full-adder b
- fa_cin  output  1  to full-adder cin
- fa_sum  input  1  from full-adder sum
- fa_cout  input  1  from full-adder cout

## Operation
- State machine: IDLE, RUN, DONE (one-hot or encoded, implementer's choice).
- IDLE: in_ready=1. When in_valid&in_ready at a clock edge:
  - latch op_a and op_b into shift registers a_sh and b_sh;
  - latch op_cin into carry_q;
  - clear the bit counter to 0;
  - go to RUN.
- RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q. These are combinational from registers only; there is no path from fa_sum/fa_cout back to fa_*.
- Each RUN edge:
  - sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
  - carry_q <= fa_cout;
  - a_sh and b_sh shift right by 1;
  - the counter increments.
- When the counter equals WIDTH-1 at an edge, that edge performs the final shift and enters DONE.
- DONE:
  - out_valid=1;
  - sum=sum_sh and cout=carry_q, held stable until the handshake completes;
  - on out_valid&out_ready, go to IDLE.
- In IDLE and DONE, fa_a, fa_b and fa_cin are driven 0.
- in_valid is ignored outside IDLE. No operand queueing.
- Arithmetic: {cout, sum} = op_a + op_b + op_cin, unsigned, exact (WIDTH+1 bits).
- Counter width is $clog2(WIDTH). It never wraps, because it exits at WIDTH-1.

## Timing
- Reset (async assert, sync-safe deassert by system):
  - state=IDLE;
  - in_ready=1;
  - out_valid=0;
  - sum=0 and cout=0;
  - fa_a, fa_b, fa_cin = 0;
  - carry_q, shift registers and counter = 0.
- Reset mid-RUN or mid-DONE abandons the operation and produces no out_valid.
- Latency: accept at edge E0 -> out_valid high after edge E0+WIDTH (exactly WIDTH RUN cycles).
- Throughput: one operation per WIDTH+2 cycles when out_ready is held high. The cycles are RUN×WIDTH, DONE×1 and IDLE×1.
- in_ready rises the cycle after the DONE handshake; it never rises combinationally from out_ready.
- out_valid backpressure: out_valid, sum and cout are unchanged while out_ready=0, for an unbounded time.
- Bit k of the operation drives fa_* during RUN cycle k (k=0..WIDTH-1), counted from the first cycle after E0.

## Test plan
- WIDTH=8, op_a=0xF0, op_b=0xCC, op_cin=0, out_ready=1:
  - fa_a sequence = 0,0,0,0,1,1,1,1;
  - fa_b sequence = 0,0,1,1,0,0,1,1;
  - out_valid 8 cycles after accept with sum=0xBC, cout=1.
- WIDTH=8, op_a=0xFF, op_b=0x00, op_cin=1 -> fa_cin=1 on every RUN cycle; sum=0x00, cout=1.
- WIDTH=8, op_a=0xAA, op_b=0x55, op_cin=0, out_ready=0 for 5 cycles:
  - sum=0xFF, cout=0 held stable;
  - in_ready=0 throughout, and an in_valid pulse with 0x01+0x01 is ignored;
  - after out_ready=1, in_ready=1 the next cycle.
- Assert rst_n=0 during RUN cycle 3 of 0x12+0x34:
  - all outputs go to reset values immediately, with no out_valid;
  - after release, 0x12+0x34+0 gives sum=0x46, cout=0.
- WIDTH=4, back-to-back with out_ready=1, in_valid held high:
  - 0x9+0x8+0 -> sum=0x1, cout=1, then 0x7+0x7+1 -> sum=0xF, cout=0;
  - second accept occurs exactly 6 cycles after the first.
- Randomised 1000 operands at WIDTH=8 with random out_ready, compared against op_a+op_b+op_cin.
